// File: rtl/universal_mod_counter.sv
// Mod-M up/down counter with saturating load, synchronous clear, registered
// compare-match pulse and sticky overflow/underflow flags.
module universal_mod_counter #(
  parameter int N = 8,
  parameter int M = 200
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         syn_clr,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic [N-1:0] d,
  input  logic [N-1:0] cmp,
  input  logic         clr_flags,
  output logic [N-1:0] q,
  output logic         max_tick,
  output logic         min_tick,
  output logic         match,
  output logic         ov,
  output logic         unf
);

  localparam logic [N-1:0] MaxVal = N'(M - 1);
  // One bit wider so M == 2**N stays representable in the load comparison.
  localparam logic [N:0]   ModVal = (N + 1)'(M);

  logic [N-1:0] cnt_q, cnt_d;
  logic         match_q, match_d;
  logic         ovf_q, ovf_d;
  logic         unf_q, unf_d;
  logic         up_wrap, down_wrap;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    if (syn_clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = ({1'b0, d} >= ModVal) ? MaxVal : d;
    end else if (en) begin
      if (up) cnt_d = (cnt_q == MaxVal) ? '0 : cnt_q + N'(1);
      else    cnt_d = (cnt_q == '0) ? MaxVal : cnt_q - N'(1);
    end
  end

  always_comb begin
    up_wrap   = en & up  & ~load & ~syn_clr & (cnt_q == MaxVal);
    down_wrap = en & ~up & ~load & ~syn_clr & (cnt_q == '0);
    // cnt_d never reaches values >= M, so an out-of-range cmp cannot match.
    match_d   = (cnt_d == cmp) && (cnt_d != cnt_q);
    ovf_d     = up_wrap   | (ovf_q & ~clr_flags);
    unf_d     = down_wrap | (unf_q & ~clr_flags);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      cnt_q   <= '0;
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      match_q <= match_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign q        = cnt_q;
  assign match    = match_q;
  assign ov       = ovf_q;
  assign unf      = unf_q;
  assign max_tick = (cnt_q == MaxVal);
  assign min_tick = (cnt_q == '0);

endmodule

// File: tb/tb_universal_mod_counter.sv
// Self-checking bench for universal_mod_counter (N=8, M=200): integer-arithmetic
// model compared every cycle, plus directed literal expectations.
module tb_universal_mod_counter;

  localparam int N = 8;
  localparam int M = 200;

  logic         clk = 1'b0;
  logic         reset, syn_clr, load, en, up, clr_flags;
  logic [N-1:0] d, cmp;
  logic [N-1:0] q;
  logic         max_tick, min_tick, match, ov, unf;

  int tests_run = 0;
  int tests_failed = 0;

  universal_mod_counter #(.N(N), .M(M)) dut (
    .clk(clk), .reset(reset), .syn_clr(syn_clr), .load(load), .en(en), .up(up),
    .d(d), .cmp(cmp), .clr_flags(clr_flags), .q(q), .max_tick(max_tick),
    .min_tick(min_tick), .match(match), .ov(ov), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: plain modular arithmetic on integers.
  int m_q = 0, m_match = 0, m_ovf = 0, m_unf = 0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    int nq;
    if (reset) begin
      m_q = 0; m_match = 0; m_ovf = 0; m_unf = 0; m_valid = 1'b1;
    end else begin
      if (syn_clr)    nq = 0;
      else if (load)  nq = (int'(d) < M) ? int'(d) : M - 1;
      else if (en)    nq = up ? (m_q + 1) % M : (m_q + M - 1) % M;
      else            nq = m_q;
      m_match = (nq == int'(cmp) && nq != m_q) ? 1 : 0;
      if (!syn_clr && !load && en && up && m_q == M - 1) m_ovf = 1;
      else if (clr_flags) m_ovf = 0;
      if (!syn_clr && !load && en && !up && m_q == 0) m_unf = 1;
      else if (clr_flags) m_unf = 0;
      m_q = nq;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_q", int'(q), m_q);
      check("model_match", int'(match), m_match);
      check("model_ov", int'(ov), m_ovf);
      check("model_unf", int'(unf), m_unf);
      check("model_max_tick", int'(max_tick), (m_q == M - 1) ? 1 : 0);
      check("model_min_tick", int'(min_tick), (m_q == 0) ? 1 : 0);
    end
  end

  // Apply current inputs at the next rising edge; return just after the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  int match_seen;

  initial begin
    reset = 1'b1; syn_clr = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
    clr_flags = 1'b0; d = '0; cmp = 8'd220;

    // 1: reset for two cycles while enabled
    tick(); tick();
    check("rst_q", int'(q), 0);
    check("rst_match", int'(match), 0);
    check("rst_ov", int'(ov), 0);
    check("rst_unf", int'(unf), 0);
    check("rst_min_tick", int'(min_tick), 1);
    check("rst_max_tick", int'(max_tick), 0);

    // 2: count up to M-1 then wrap
    reset = 1'b0;
    repeat (199) tick();
    check("up_q199", int'(q), 199);
    check("up_max_tick", int'(max_tick), 1);
    tick();
    check("up_wrap_q", int'(q), 0);
    check("up_wrap_ov", int'(ov), 1);
    check("up_wrap_min_tick", int'(min_tick), 1);

    // 3: count down through zero
    up = 1'b0;
    tick();
    check("dn_wrap_q", int'(q), 199);
    check("dn_wrap_unf", int'(unf), 1);
    tick();
    check("dn_q198", int'(q), 198);
    check("dn_unf_sticky", int'(unf), 1);

    // 4: loads
    en = 1'b0; load = 1'b1; d = 8'd250;
    tick();
    check("load_sat", int'(q), 199);
    cmp = 8'd17; d = 8'd17;
    tick();
    check("load_17", int'(q), 17);
    check("load_onto_cmp_match", int'(match), 1);
    tick();
    check("reload_17_no_match", int'(match), 0);
    syn_clr = 1'b1;
    tick();
    check("clr_beats_load", int'(q), 0);
    syn_clr = 1'b0; en = 1'b1; up = 1'b1; d = 8'd40;
    tick();
    check("load_beats_en", int'(q), 40);
    load = 1'b0; en = 1'b0;

    // 5: compare match
    cmp = 8'd5; syn_clr = 1'b1;
    tick();
    syn_clr = 1'b0; en = 1'b1; up = 1'b1;
    repeat (4) tick();
    check("cmp_q4_no_match", int'(match), 0);
    tick();
    check("cmp_q5", int'(q), 5);
    check("cmp_match", int'(match), 1);
    en = 1'b0;
    tick();
    check("cmp_hold_q", int'(q), 5);
    check("cmp_hold_no_match", int'(match), 0);
    cmp = 8'd220; en = 1'b1;
    match_seen = 0;
    for (int i = 0; i < 250; i++) begin
      tick();
      if (match) match_seen++;
    end
    check("cmp_out_of_range_matches", match_seen, 0);
    check("cmp_range_q", int'(q), 55);

    // 6: flag clear priority, reset mid-count
    en = 1'b0; clr_flags = 1'b1;
    tick();
    check("clr_ov", int'(ov), 0);
    check("clr_unf", int'(unf), 0);
    clr_flags = 1'b0; load = 1'b1; d = 8'd199;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1; clr_flags = 1'b1;
    tick();
    check("set_beats_clr_q", int'(q), 0);
    check("set_beats_clr_ov", int'(ov), 1);
    en = 1'b0;
    tick();
    check("clr_alone_ov", int'(ov), 0);
    clr_flags = 1'b0; load = 1'b1; d = 8'd123;
    tick();
    check("load_123", int'(q), 123);
    load = 1'b0; reset = 1'b1; en = 1'b1;
    tick();
    check("mid_reset_q", int'(q), 0);
    reset = 1'b0;
    tick();
    check("post_reset_q", int'(q), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
